cp0_reg: RTL
============

# cp0_reg

Coprocessor-0 register file for the five-stage MIPS core, placed directly downstream of the exception-type encoder in the memory stage. It consumes the 32-bit encoded exception type, the faulting PC, the delay-slot flag and the bad address. It then updates Status/Cause/EPC/BadVAddr, runs the Count/Compare timer and serves `mtc0`/`mfc0` accesses. Its Status and Cause outputs feed back into the encoder for interrupt detection.

## Interface
- `RST_STATUS`, 32'h0040_0000, Status reset value (BEV=1, EXL=0, IE=0)
- `clk`  in  1  core clock
- `rst`  in  1  reset, synchronous, active-high
- `we_i`  in  1  `mtc0` write enable (memory stage)
- `waddr_i`  in  5  `mtc0` register number
- `raddr_i`  in  5  `mfc0` register number
- `data_i`  in  32  `mtc0` write data
- `int_i`  in  6  external hardware interrupts, level-sensitive
- `except_type_i`  in  32  encoded exception: 0 none, 1 int, 4 AdEL, 5 AdES, 8 Sys, 9 Bp, a RI, c Ov, e Eret
- `current_inst_addr_i`  in  32  PC of the memory-stage instruction
- `is_in_delayslot_i`  in  1  instruction sits in a branch delay slot
- `bad_addr_i`  in  32  faulting address for AdEL/AdES
- `data_o`  out  32  `mfc0` read data, combinational
- `count_o`, `compare_o`, `status_o`, `cause_o`, `epc_o`, `badvaddr_o`  out  32 each  register contents
- `timer_int_o`  out  1  timer interrupt pending

## Operation
- Registers and their numbers: BadVAddr 8, Count 9, Compare 11, Status 12, Cause 13, EPC 14. Reading any other number returns 0.
- Reset values:
  - Status = `RST_STATUS`.
  - All other registers, `timer_int_o` and the tick flop = 0.
- Count: an internal tick flop toggles every cycle; Count increments (mod 2^32, wraps silently) on cycles where tick=1, i.e. half clock rate.
- Timer:
  - `timer_int_o` sets on the cycle after Count==Compare while Compare≠0.
  - It stays set until an `mtc0` to Compare, which clears it.
- Cause.IP[7:2] (bits 15:10) is loaded with `int_i` every cycle. The top level ties `timer_int_o` into `int_i[5]`.
- `mtc0` write masks:
  - Count, Compare, EPC: full 32 bits.
  - Status: bits 15:8 (IM), 1 (EXL) and 0 (IE) only.
  - Cause: bits 9:8 (software IP) only.
  - BadVAddr: read-only.
- Exception commit, when `except_type_i` ∉ {0, e}:
  - EPC ← `is_in_delayslot_i` ? PC−4 : PC.
  - Cause.BD (bit 31) ← `is_in_delayslot_i`.
  - Status.EXL ← 1.
  - Cause.ExcCode[6:2] ← code: int→0x00, 4→0x04, 5→0x05, 8→0x08, 9→0x09, a→0x0a, c→0x0c.
  - BadVAddr ← `bad_addr_i` for types 4 and 5 only.
- Nested exception while EXL=1: EPC and Cause.BD are NOT updated; ExcCode, BadVAddr and EXL are still written.
- Eret (e): Status.EXL ← 0. Nothing else changes.
- Any other nonzero type: no register update.

## Timing
- All updates land at the rising edge after the inputs are valid; there is no multi-cycle latency.
- `data_o` reflects register state before the current edge. A same-cycle `mtc0`/`mfc0` to the same register returns the old value; the pipeline forwards externally.
- Simultaneous exception (nonzero `except_type_i`) and `we_i`: the `mtc0` write is dropped entirely, because the instruction is being flushed.
- Simultaneous `mtc0` to Count and a tick: the written value wins; the increment is lost.
- Simultaneous `mtc0` to Compare and a Count==Compare match: the clear wins, and `timer_int_o` = 0 next cycle.
- `rst` asserted mid-operation overrides everything on that edge, including pending exceptions.

## Structure
- Shared package `cp0_defs` holds:
  - register numbers (`CP0_BADVADDR` … `CP0_EPC`)
  - exception-type encodings (`EXC_INT` … `EXC_ERET`)
  - ExcCode values
  - Status/Cause bit positions and write masks
- One sub-module, `cp0_timer`, is natural: it contains the tick flop, Count, Compare and `timer_int_o`, and takes write strobes from the parent.
- Everything else lives flat in `cp0_reg`.

## Test plan
- Reset, then idle 10 cycles → Status=0x00400000, Count=5, Cause=0, EPC=0.
- Timer interrupt:
  - `mtc0` Compare=0x10 at Count=0 → `timer_int_o`=1 once Count reaches 0x10.
  - `mtc0` Compare=0x20 → `timer_int_o`=0 next cycle.
- Exception in delay slot: `except_type_i`=0xc, PC=0xbfc0_0104, delay slot=1 → EPC=0xbfc0_0100, Cause[31]=1, ExcCode=0x0c, Status.EXL=1.
- Address error: `except_type_i`=0x4, bad_addr=0x8000_0003 → BadVAddr=0x8000_0003, ExcCode=0x04. A second exception with EXL=1 leaves EPC unchanged. Eret → EXL=0.
- Write masks and priority:
  - `mtc0` Status=0xFFFF_FFFF → Status=0x0040_FF03.
  - `mtc0` Cause=0xFFFF_FFFF with `int_i`=0 → Cause=0x0000_0300.
  - `mtc0` EPC concurrent with `except_type_i`=0x8 → EPC = exception value, not written data.
- Interrupt sampling: `int_i`=6'b000101 → Cause[15:10]=6'b000101 one cycle later.

Source files
------------

// File: rtl/cp0_reg_pkg.sv
// cp0_defs: register numbers, exception encodings, ExcCodes and bit masks shared by the CP0 block.
package cp0_defs;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam logic [31:0] EXC_NONE = 32'h0;
    localparam logic [31:0] EXC_INT  = 32'h1;
    localparam logic [31:0] EXC_ADEL = 32'h4;
    localparam logic [31:0] EXC_ADES = 32'h5;
    localparam logic [31:0] EXC_SYS  = 32'h8;
    localparam logic [31:0] EXC_BP   = 32'h9;
    localparam logic [31:0] EXC_RI   = 32'ha;
    localparam logic [31:0] EXC_OV   = 32'hc;
    localparam logic [31:0] EXC_ERET = 32'he;

    localparam logic [4:0] CODE_INT  = 5'h00;
    localparam logic [4:0] CODE_ADEL = 5'h04;
    localparam logic [4:0] CODE_ADES = 5'h05;
    localparam logic [4:0] CODE_SYS  = 5'h08;
    localparam logic [4:0] CODE_BP   = 5'h09;
    localparam logic [4:0] CODE_RI   = 5'h0a;
    localparam logic [4:0] CODE_OV   = 5'h0c;

    localparam logic [31:0] RST_STATUS_DEF = 32'h0040_0000;
    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;
    localparam int CAUSE_BD   = 31;
    localparam int CAUSE_IP_LO = 10;
    localparam int CAUSE_EXC_LO = 2;
    localparam logic [31:0] STATUS_WMASK = 32'h0000_ff03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

    // {taken, ExcCode}; taken is 0 for none, Eret and unrecognised types
    function automatic logic [5:0] exc_decode(input logic [31:0] t);
        case (t)
            EXC_INT:  exc_decode = {1'b1, CODE_INT};
            EXC_ADEL: exc_decode = {1'b1, CODE_ADEL};
            EXC_ADES: exc_decode = {1'b1, CODE_ADES};
            EXC_SYS:  exc_decode = {1'b1, CODE_SYS};
            EXC_BP:   exc_decode = {1'b1, CODE_BP};
            EXC_RI:   exc_decode = {1'b1, CODE_RI};
            EXC_OV:   exc_decode = {1'b1, CODE_OV};
            default:  exc_decode = 6'd0;
        endcase
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: half-rate Count, Compare and the sticky timer interrupt.
module cp0_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_int
);
    logic tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            tick      <= 1'b0;
            count     <= 32'd0;
            compare   <= 32'd0;
            timer_int <= 1'b0;
        end else begin
            tick      <= ~tick;
            count     <= count_we ? wdata : count + {31'd0, tick};
            compare   <= compare_we ? wdata : compare;
            timer_int <= compare_we ? 1'b0 : (compare != 32'd0 && count == compare) ? 1'b1 : timer_int;
        end
    end
endmodule

// File: rtl/cp0_reg.sv
// cp0_reg: CP0 register file handling exception commit, Eret, mtc0/mfc0 and the Count/Compare timer.
module cp0_reg
    import cp0_defs::*;
#(
    parameter logic [31:0] RST_STATUS = RST_STATUS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [4:0]  raddr_i,
    input  logic [31:0] data_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] except_type_i,
    input  logic [31:0] current_inst_addr_i,
    input  logic        is_in_delayslot_i,
    input  logic [31:0] bad_addr_i,
    output logic [31:0] data_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] badvaddr_o,
    output logic        timer_int_o
);
    logic [5:0] dec;
    logic       take, wr;

    assign dec  = exc_decode(except_type_i);
    assign take = dec[5];
    // any nonzero type flushes the instruction, so its mtc0 is dropped
    assign wr   = we_i && except_type_i == EXC_NONE;

    cp0_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (wr && waddr_i == CP0_COUNT),
        .compare_we (wr && waddr_i == CP0_COMPARE),
        .wdata      (data_i),
        .count      (count_o),
        .compare    (compare_o),
        .timer_int  (timer_int_o)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            status_o   <= RST_STATUS;
            cause_o    <= 32'd0;
            epc_o      <= 32'd0;
            badvaddr_o <= 32'd0;
        end else begin
            cause_o[CAUSE_IP_LO +: 6] <= int_i;
            if (take) begin
                if (!status_o[STATUS_EXL]) begin
                    epc_o             <= is_in_delayslot_i ? current_inst_addr_i - 32'd4 : current_inst_addr_i;
                    cause_o[CAUSE_BD] <= is_in_delayslot_i;
                end
                status_o[STATUS_EXL]       <= 1'b1;
                cause_o[CAUSE_EXC_LO +: 5] <= dec[4:0];
                if (except_type_i == EXC_ADEL || except_type_i == EXC_ADES)
                    badvaddr_o <= bad_addr_i;
            end else if (except_type_i == EXC_ERET) begin
                status_o[STATUS_EXL] <= 1'b0;
            end else if (wr) begin
                if (waddr_i == CP0_STATUS)
                    status_o <= (status_o & ~STATUS_WMASK) | (data_i & STATUS_WMASK);
                if (waddr_i == CP0_CAUSE)
                    cause_o[9:8] <= data_i[9:8];
                if (waddr_i == CP0_EPC)
                    epc_o <= data_i;
            end
        end
    end

    always_comb begin
        data_o = raddr_i == CP0_BADVADDR ? badvaddr_o :
                 raddr_i == CP0_COUNT    ? count_o    :
                 raddr_i == CP0_COMPARE  ? compare_o  :
                 raddr_i == CP0_STATUS   ? status_o   :
                 raddr_i == CP0_CAUSE    ? cause_o    :
                 raddr_i == CP0_EPC      ? epc_o      : 32'd0;
    end
endmodule
